// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding,
// register-index constants and default parameter values.
package pipeline_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StMdBusy  = 2'd2
  } hcu_state_e;

  localparam logic [4:0]  REG_X0         = 5'd0;
  localparam int unsigned CNT_W_DEF      = 32;
  localparam int unsigned MD_TIMEOUT_DEF = 64;
  localparam int unsigned TMO_W_DEF      = 7;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stall/flush generation for load-use, redirects, data-memory
// waits and MUL/DIV occupancy, plus saturating stall/flush performance counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned MD_TIMEOUT = MD_TIMEOUT_DEF,
  parameter int unsigned TMO_W      = TMO_W_DEF
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_redirect,
  input  logic             i_ex_md_start,
  input  logic             i_md_done,
  input  logic             i_dmem_req,
  input  logic             i_dmem_ready,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_md_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  hcu_state_e       r_state, w_state_d;
  logic [TMO_W-1:0] r_md_cnt, w_md_cnt_d;
  logic             r_md_timeout, w_md_timeout_d;

  logic w_mem_wait, w_load_use;
  logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush;
  logic w_exmem_stall, w_exmem_flush;

  assign w_mem_wait = i_dmem_req & ~i_dmem_ready;
  assign w_load_use = i_ex_memread & (i_ex_rd != REG_X0) &
                      ((i_id_use_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_use_rs2 & (i_id_rs2 == i_ex_rd)));

  always_comb begin
    w_state_d      = r_state;
    w_md_cnt_d     = r_md_cnt;
    w_md_timeout_d = r_md_timeout;
    w_pc_stall     = 1'b0;
    w_ifid_stall   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_stall   = 1'b0;
    w_idex_flush   = 1'b0;
    w_exmem_stall  = 1'b0;
    w_exmem_flush  = 1'b0;
    unique case (r_state)
      StRun: begin
        if (w_mem_wait) begin
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
          w_state_d = StMemWait;
        end else if (i_ex_md_start && !i_md_done) begin
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_flush} = 4'b1111;
          w_state_d  = StMdBusy;
          w_md_cnt_d = TMO_W'(1);
        end else if (i_ex_redirect) begin
          // Redirect wins over load-use: the dependent instruction is squashed.
          {w_ifid_flush, w_idex_flush} = 2'b11;
        end else if (w_load_use) begin
          {w_pc_stall, w_ifid_stall, w_idex_flush} = 3'b111;
        end
      end
      StMemWait: begin
        {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
        if (i_dmem_ready) w_state_d = StRun;
      end
      StMdBusy: begin
        if (w_mem_wait) begin
          // MEM stage blocked: freeze everything, MUL/DIV cycle count held.
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_stall} = 4'b1111;
        end else if (i_md_done) begin
          w_state_d = StRun;
        end else if (r_md_cnt == TMO_W'(MD_TIMEOUT)) begin
          w_md_timeout_d = 1'b1;
          w_state_d      = StRun;
        end else begin
          {w_pc_stall, w_ifid_stall, w_idex_stall, w_exmem_flush} = 4'b1111;
          w_md_cnt_d = r_md_cnt + 1'b1;
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= StRun;
      r_md_cnt     <= '0;
      r_md_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_md_cnt     <= w_md_cnt_d;
      r_md_timeout <= w_md_timeout_d;
    end
  end

  // Gate with reset so inputs cannot raise controls while reset is held.
  assign o_pc_stall    = w_pc_stall    & i_reset_n;
  assign o_ifid_stall  = w_ifid_stall  & i_reset_n;
  assign o_ifid_flush  = w_ifid_flush  & i_reset_n;
  assign o_idex_stall  = w_idex_stall  & i_reset_n;
  assign o_idex_flush  = w_idex_flush  & i_reset_n;
  assign o_exmem_stall = w_exmem_stall & i_reset_n;
  assign o_exmem_flush = w_exmem_flush & i_reset_n;
  assign o_md_timeout  = r_md_timeout;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_en      (o_pc_stall),
    .o_count   (o_stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_en      (o_idex_flush),
    .o_count   (o_flush_events)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: vector table plus hand sequences,
// with a default-width instance and a 4-bit-counter instance for saturation.
module tb_hazard_control_unit;

  localparam int unsigned MdTmo = 64;
  // Control word order: {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exmem_st, exmem_fl}
  localparam logic [6:0] E0   = 7'b0000000;
  localparam logic [6:0] ELu  = 7'b1100100;
  localparam logic [6:0] ERd  = 7'b0010100;
  localparam logic [6:0] EFrz = 7'b1101010;
  localparam logic [6:0] EMd  = 7'b1101001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       use1, use2, memread, redir, mds, mdd, dreq, drdy;

  logic        pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exm_st, exm_fl, tmo;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_st, s_ifid_st, s_ifid_fl, s_idex_st, s_idex_fl, s_exm_st, s_exm_fl, s_tmo;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [6:0] ctl, s_ctl;
  assign ctl   = {pc_st, ifid_st, ifid_fl, idex_st, idex_fl, exm_st, exm_fl};
  assign s_ctl = {s_pc_st, s_ifid_st, s_ifid_fl, s_idex_st, s_idex_fl, s_exm_st, s_exm_fl};

  hazard_control_unit dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_memread(memread), .i_ex_rd(rd),
    .i_ex_redirect(redir), .i_ex_md_start(mds), .i_md_done(mdd), .i_dmem_req(dreq),
    .i_dmem_ready(drdy), .o_pc_stall(pc_st), .o_ifid_stall(ifid_st), .o_ifid_flush(ifid_fl),
    .o_idex_stall(idex_st), .o_idex_flush(idex_fl), .o_exmem_stall(exm_st),
    .o_exmem_flush(exm_fl), .o_md_timeout(tmo), .o_stall_cycles(stall_cnt),
    .o_flush_events(flush_cnt)
  );

  hazard_control_unit #(.CNT_W(4)) dut_small (
    .i_clock(clk), .i_reset_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_memread(memread), .i_ex_rd(rd),
    .i_ex_redirect(redir), .i_ex_md_start(mds), .i_md_done(mdd), .i_dmem_req(dreq),
    .i_dmem_ready(drdy), .o_pc_stall(s_pc_st), .o_ifid_stall(s_ifid_st),
    .o_ifid_flush(s_ifid_fl), .o_idex_stall(s_idex_st), .o_idex_flush(s_idex_fl),
    .o_exmem_stall(s_exm_st), .o_exmem_flush(s_exm_fl), .o_md_timeout(s_tmo),
    .o_stall_cycles(s_stall_cnt), .o_flush_events(s_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       memread;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       use1;
    logic [4:0] rs2;
    logic       use2;
    logic       redir, mds, mdd, dreq, drdy;
    logic [6:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_stall = '0, exp_flush = '0;
  logic [3:0]  exp_s_stall = '0, exp_s_flush = '0;
  logic        exp_tmo = 1'b0;
  vec_t        sb_q[$];
  vec_t        tbl[$];

  function automatic vec_t mk(string n, logic mr, logic [4:0] d, logic [4:0] r1, logic u1,
                              logic [4:0] r2, logic u2, logic rdr, logic ms, logic md,
                              logic dq, logic dy, logic [6:0] e);
    vec_t v;
    v.name = n; v.memread = mr; v.rd = d; v.rs1 = r1; v.use1 = u1; v.rs2 = r2; v.use2 = u2;
    v.redir = rdr; v.mds = ms; v.mdd = md; v.dreq = dq; v.drdy = dy; v.exp = e;
    return v;
  endfunction

  function automatic vec_t zv(string n);
    return mk(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, E0);
  endfunction

  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, req);
    end
  endtask

  task automatic run_vec(input vec_t v);
    vec_t got;
    memread = v.memread; rd = v.rd; rs1 = v.rs1; use1 = v.use1; rs2 = v.rs2; use2 = v.use2;
    redir = v.redir; mds = v.mds; mdd = v.mdd; dreq = v.dreq; drdy = v.drdy;
    sb_q.push_back(v);
    @(negedge clk);
    got = sb_q.pop_front();
    check({got.name, "/ctl"}, 32'(ctl), 32'(got.exp));
    check({got.name, "/ctl_small"}, 32'(s_ctl), 32'(got.exp));
    check({got.name, "/stall_cycles"}, stall_cnt, exp_stall);
    check({got.name, "/flush_events"}, flush_cnt, exp_flush);
    check({got.name, "/stall_small"}, 32'(s_stall_cnt), 32'(exp_s_stall));
    check({got.name, "/flush_small"}, 32'(s_flush_cnt), 32'(exp_s_flush));
    check({got.name, "/md_timeout"}, 32'({tmo, s_tmo}), 32'({exp_tmo, exp_tmo}));
    // No pipeline register may see stall and flush together.
    check({got.name, "/stall_flush_excl"},
          32'({ifid_st & ifid_fl, idex_st & idex_fl, exm_st & exm_fl}), 32'(0));
    if (got.exp[6]) begin
      exp_stall++;
      if (exp_s_stall != 4'hF) exp_s_stall++;
    end
    if (got.exp[2]) begin
      exp_flush++;
      if (exp_s_flush != 4'hF) exp_s_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    {memread, redir, mds, mdd, dreq, drdy, use1, use2} = '0;
    rs1 = '0; rs2 = '0; rd = '0;
    #3;
    check("reset/ctl", 32'({ctl, s_ctl}), 32'(0));
    check("reset/counters", stall_cnt | flush_cnt, 32'(0));
    check("reset/md_timeout", 32'({tmo, s_tmo}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    tbl.push_back(zv("idle"));
    tbl.push_back(mk("load_use_rs1", 1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, ELu));
    tbl.push_back(zv("after_load_use"));
    tbl.push_back(mk("load_use_rs2", 1, 7, 3, 1, 7, 1, 0, 0, 0, 0, 0, ELu));
    tbl.push_back(mk("match_not_used", 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, E0));
    tbl.push_back(mk("load_x0", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, E0));
    tbl.push_back(mk("redirect_load_use", 1, 5, 5, 1, 0, 0, 1, 0, 0, 0, 0, ERd));
    tbl.push_back(mk("redirect_only", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ERd));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("mem_wait", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, EFrz));
    tbl.push_back(mk("mem_ready", 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, EFrz));
    tbl.push_back(mk("mem_redirect", 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, ERd));
    tbl.push_back(zv("after_mem"));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("md_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, EMd));
    tbl.push_back(mk("md_done", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E0));
    tbl.push_back(zv("after_md"));
    tbl.push_back(mk("md_enter", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, EMd));
    tbl.push_back(mk("md_mem_freeze", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, EFrz));
    tbl.push_back(mk("md_mem_ready", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, EMd));
    tbl.push_back(mk("md_done2", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, E0));
    tbl.push_back(zv("after_md2"));
    foreach (tbl[i]) run_vec(tbl[i]);

    // MUL/DIV timeout: MdTmo stall cycles, then release and a sticky error flag.
    for (int i = 0; i < int'(MdTmo); i++)
      run_vec(mk("md_tmo_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, EMd));
    run_vec(mk("md_tmo_release", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, E0));
    exp_tmo = 1'b1;
    run_vec(zv("md_tmo_sticky1"));
    run_vec(zv("md_tmo_sticky2"));

    // Reset asserted mid-cycle while in MD_BUSY with the MD request still held.
    run_vec(mk("rst_md_enter", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, EMd));
    run_vec(mk("rst_md_busy", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, EMd));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/ctl", 32'({ctl, s_ctl}), 32'(0));
    check("rst_mid/counters", stall_cnt | flush_cnt, 32'(0));
    check("rst_mid/md_timeout", 32'({tmo, s_tmo}), 32'(0));
    @(posedge clk);
    #1;
    mds = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_stall = '0; exp_flush = '0; exp_s_stall = '0; exp_s_flush = '0; exp_tmo = 1'b0;
    @(posedge clk);
    #1;
    run_vec(zv("after_rst_run"));

    // Saturation of the 4-bit counters.
    for (int i = 0; i < 20; i++)
      run_vec(mk("sat_load_use", 1, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, ELu));
    run_vec(zv("sat_hold1"));
    run_vec(zv("sat_hold2"));
    check("sat/stall_small_15", 32'(s_stall_cnt), 32'd15);
    check("sat/stall_wide_20", stall_cnt, 32'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
